noc_outport_arbiter: RTL and testbench



---
 rtl/noc_outport_arbiter_pkg.sv | 18 +
 rtl/noc_outport_arbiter_rr_pick.sv | 33 +++
 rtl/noc_outport_arbiter.sv | 128 ++++++++++++
 tb/tb_noc_outport_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_outport_arbiter_pkg.sv
// Types and constants shared by the output-port arbiter and its round-robin picker.
package noc_outport_arbiter_pkg;

  // Number of input ports that compete for one output port.
  localparam int NEXTHOPWIDTH = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_LOCK  = 2'd2
  } arb_state_t;

  // Width of a port index. It never goes below 1 bit, so a single-port build still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_outport_arbiter_rr_pick.sv
// Round-robin picker. It returns the first requester at or after rr_ptr, wrapping around.
module noc_outport_arbiter_rr_pick
  import noc_outport_arbiter_pkg::*;
#(
  parameter  int NPORT = NEXTHOPWIDTH,
  localparam int PW    = ptr_width(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [NPORT-1:0] win_onehot,
  output logic [PW-1:0]    win_idx,
  output logic             win_valid
);

  // Walk the ports in priority order starting at rr_ptr. The first request found wins.
  always_comb begin
    int j;
    j          = 0;
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NPORT) j = j - NPORT;
      if (!win_valid && req[j]) begin
        win_valid     = 1'b1;
        win_onehot[j] = 1'b1;
        win_idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/noc_outport_arbiter.sv
// Output-port arbiter. It grants round-robin, holds the grant from head to tail,
// and has a stall watchdog that frees a lock which has wedged.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no grant; arbitrate among requesters starting at rr_ptr
// ARB_GRANT | sel driven, no flit of the packet has moved yet
// ARB_LOCK  | head has moved, tail has not; other inputs are ignored
module noc_outport_arbiter
  import noc_outport_arbiter_pkg::*;
#(
  parameter int NPORT   = NEXTHOPWIDTH,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             oktosend,
  output logic [NPORT-1:0] sel,
  output logic [NPORT-1:0] override_oth,
  output logic [NPORT-1:0] ack,
  output logic             busy,
  output logic             err_timeout
);

  localparam int PW = ptr_width(NPORT);

  arb_state_t       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    owner_next;
  logic [TO_W-1:0]  wdog;
  logic [NPORT-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic             xfer;
  logic             xfer_tail;
  logic             owner_req;
  logic             wdog_tc;

  noc_outport_arbiter_rr_pick #(.NPORT(NPORT)) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Pop strobe and transfer qualifiers. At most one ack bit is set because sel is one-hot.
  always_comb begin
    ack        = sel & req & {NPORT{oktosend}};
    xfer       = |ack;
    xfer_tail  = |(ack & tail);
    owner_req  = |(sel & req);
    owner_next = (int'(owner) == NPORT - 1) ? '0 : owner + PW'(1);
    wdog_tc    = (wdog == TO_W'(TIMEOUT - 1));
  end

  // Arbitration FSM with registered outputs. A tail transfer takes priority over
  // watchdog expiry in the same cycle, so that cycle releases without an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      sel          <= '0;
      override_oth <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      rr_ptr       <= '0;
      owner        <= '0;
      wdog         <= '0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            sel   <= pick_onehot;
            owner <= pick_idx;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer) begin
            if (xfer_tail) begin
              sel    <= '0;
              rr_ptr <= owner_next;
              state  <= ARB_IDLE;
            end else begin
              override_oth <= sel;
              busy         <= 1'b1;
              wdog         <= '0;
              state        <= ARB_LOCK;
            end
          end else if (!owner_req) begin
            // The requester went away before moving anything, so the pointer does not advance.
            sel   <= '0;
            state <= ARB_IDLE;
          end
        end
        ARB_LOCK: begin
          if (xfer_tail || (!xfer && wdog_tc)) begin
            sel          <= '0;
            override_oth <= '0;
            busy         <= 1'b0;
            rr_ptr       <= owner_next;
            wdog         <= '0;
            err_timeout  <= !xfer;
            state        <= ARB_IDLE;
          end else if (xfer) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end
        default: begin
          sel          <= '0;
          override_oth <= '0;
          busy         <= 1'b0;
          wdog         <= '0;
          state        <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// Bench for noc_outport_arbiter. A packet-level reference model is checked every
// cycle, and directed scenarios carry hand-computed literal expectations.
module tb_noc_outport_arbiter;

  localparam int N  = 5;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail = '0;
  logic         oktosend = 1'b0;
  logic [N-1:0] sel, override_oth, ack;
  logic         busy, err_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  // Reference model: which input owns the port, whether a packet is in flight,
  // the round-robin start point, the count of stalled cycles, and the timeout pulse.
  int m_owner = -1;
  bit m_mid   = 1'b0;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;
  bit m_xfer;

  noc_outport_arbiter #(.NPORT(N), .TIMEOUT(TO), .TO_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .tail         (tail),
    .oktosend     (oktosend),
    .sel          (sel),
    .override_oth (override_oth),
    .ack          (ack),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_sel();
    logic [N-1:0] one;
    one = 1;
    return (m_owner >= 0) ? (one << m_owner) : '0;
  endfunction

  // Advance the model on each clock edge, using the inputs that were presented during that cycle.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_mid = 0; m_ptr = 0; m_stall = 0; m_err = 0;
    end else begin
      m_err  = 0;
      m_xfer = (m_owner >= 0) && req[m_owner] && oktosend;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++)
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
      end else if (m_xfer && tail[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_mid = 0; m_stall = 0;
      end else if (m_xfer) begin
        m_mid = 1; m_stall = 0;
      end else if (!m_mid) begin
        if (!req[m_owner]) m_owner = -1;
      end else if (m_stall == TO - 1) begin
        m_err = 1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_mid = 0; m_stall = 0;
      end else begin
        m_stall++;
      end
    end
  end

  // Compare the DUT against the model and check the invariants at every falling edge.
  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      chk("sel", sel, model_sel());
      chk("override_oth", override_oth, m_mid ? model_sel() : '0);
      chk("busy", N'(busy), N'(m_mid));
      chk("err_timeout", N'(err_timeout), N'(m_err));
      chk("ack", ack, model_sel() & req & {N{oktosend}});
      chk("sel_onehot0", N'($onehot0(sel)), N'(1));
      chk("ovr_subset_sel", override_oth & ~sel, '0);
      chk("ack_subset_sel", ack & ~sel, '0);
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl, input logic ok);
    @(posedge clk);
    #1;
    rst = r; req = rq; tail = tl; oktosend = ok;
    #1;
  endtask

  logic [N-1:0] t2_exp [7] = '{5'b00000, 5'b00100, 5'b00000, 5'b00001, 5'b00000, 5'b00100, 5'b00000};

  initial begin
    // Reset
    cyc(1, '0, '0, 0);
    run_chk = 1'b1;
    cyc(1, '0, '0, 0);
    cyc(0, 5'b00001, 5'b00001, 1);
    chk("rst_sel", sel, '0);
    chk("rst_ovr", override_oth, '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_err", N'(err_timeout), '0);
    chk("rst_ack", ack, '0);
    // Single-flit packet from input 0, then the pointer moves on to 1
    cyc(0, 5'b00001, 5'b00001, 1);
    chk("t1_sel", sel, 5'b00001);
    chk("t1_ack", ack, 5'b00001);
    cyc(0, '0, '0, 1);
    chk("t1_rel", sel, '0);
    cyc(0, 5'b00011, 5'b00011, 1);
    cyc(0, 5'b00011, 5'b00011, 1);
    chk("t1_ptr1", sel, 5'b00010);
    cyc(0, '0, '0, 1);
    // Inputs 0 and 2 alternate, with an idle cycle between grants
    for (int k = 0; k < 7; k++) begin
      cyc(0, 5'b00101, 5'b00101, 1);
      chk("t2_alt", sel, t2_exp[k]);
    end
    cyc(0, '0, '0, 1);
    chk("t2_drop_sel", sel, 5'b00001);
    chk("t2_drop_ack", ack, '0);
    cyc(0, '0, '0, 1);
    chk("t2_drop_rel", sel, '0);
    // Four-flit packet from input 1 while input 3 waits
    cyc(0, 5'b00010, '0, 1);
    cyc(0, 5'b01010, '0, 1);
    chk("t3_f1_sel", sel, 5'b00010);
    chk("t3_f1_ovr", override_oth, '0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 5'b01010, '0, 1);
      chk("t3_mid_sel", sel, 5'b00010);
      chk("t3_mid_ovr", override_oth, 5'b00010);
    end
    cyc(0, 5'b01010, 5'b00010, 1);
    chk("t3_tail_ack", ack, 5'b00010);
    cyc(0, 5'b01000, 5'b01000, 1);
    chk("t3_gap_sel", sel, '0);
    chk("t3_gap_ovr", override_oth, '0);
    cyc(0, 5'b01000, 5'b01000, 1);
    chk("t3_next", sel, 5'b01000);
    cyc(0, '0, '0, 1);
    // Watchdog expiry while input 0 holds the lock and input 2 waits
    cyc(0, 5'b00001, '0, 1);
    cyc(0, 5'b00101, '0, 1);
    chk("t4_head", ack, 5'b00001);
    for (int s = 0; s < TO; s++) begin
      cyc(0, 5'b00101, '0, 0);
      chk("t4_stall_sel", sel, 5'b00001);
      chk("t4_stall_err", N'(err_timeout), '0);
    end
    cyc(0, 5'b00101, 5'b00101, 1);
    chk("t4_to_err", N'(err_timeout), N'(1));
    chk("t4_to_sel", sel, '0);
    cyc(0, 5'b00101, 5'b00101, 1);
    chk("t4_next_sel", sel, 5'b00100);
    chk("t4_next_err", N'(err_timeout), '0);
    cyc(0, '0, '0, 1);
    // Credit toggles during a lock; stalls never add up to an expiry
    cyc(0, 5'b00001, '0, 1);
    cyc(0, 5'b00001, '0, 1);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 5'b00001, '0, logic'(i % 2));
      chk("t5_ack", ack, (i % 2) ? 5'b00001 : 5'b00000);
      chk("t5_err", N'(err_timeout), '0);
    end
    cyc(0, 5'b00001, 5'b00001, 1);
    chk("t5_tail", ack, 5'b00001);
    cyc(0, '0, '0, 1);
    // Reset in the middle of a packet
    cyc(0, 5'b00100, '0, 1);
    cyc(0, 5'b00100, '0, 1);
    cyc(1, 5'b00100, '0, 1);
    chk("t6_pre_ovr", override_oth, 5'b00100);
    cyc(0, 5'b10001, 5'b10001, 1);
    chk("t6_sel", sel, '0);
    chk("t6_ovr", override_oth, '0);
    chk("t6_busy", N'(busy), '0);
    cyc(0, 5'b10001, 5'b10001, 1);
    chk("t6_ptr0", sel, 5'b00001);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);
    @(posedge clk);
    #1;
    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
